wave_render: RTL

WAVE_RENDER -- requirements
Module: wave_render

---
 rtl/wave_pkg.sv | 16 +
 rtl/wave_line_compare.sv | 19 +
 rtl/wave_render.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform renderer and the capture side.
package wave_pkg;

  typedef enum logic {
    OUTSIDE = 1'b0,
    DRAWING = 1'b1
  } wave_state_e;

  // Waveform window: 512 columns x 512 rows in the top-left of the display.
  localparam logic [10:0] WAVE_COLS = 11'd512;
  localparam logic [9:0]  WAVE_ROWS = 10'd512;

  localparam logic [7:0] COLOR_LIT   = 8'hFF;
  localparam logic [7:0] COLOR_UNLIT = 8'h00;

endpackage

// File: rtl/wave_line_compare.sv
// Decides whether a display level falls between two adjacent samples.
module wave_line_compare (
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  input  logic [7:0] row,
  output logic       lit
);

  logic [7:0] lo;
  logic [7:0] hi;

  // Order the two samples and test the row against the closed range.
  always_comb begin
    lo  = (prev < cur) ? prev : cur;
    hi  = (prev < cur) ? cur  : prev;
    lit = (row >= lo) && (row <= hi);
  end

endmodule

// File: rtl/wave_render.sv
// Renders one RAM half of 8-bit samples as a white trace in a 512x512 window.
module wave_render
  import wave_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        wave_display_idle,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  wave_state_e state_q;
  logic        disp_index_q;

  logic        entry;
  logic        in_window;
  logic        drawing;

  // Stage-1 copies of the pixel coordinates; only y[8:1] selects a level.
  logic        valid1_q;
  logic        win1_q;
  logic        draw1_q;
  logic [8:0]  x1_q;
  logic [7:0]  yh1_q;

  logic [7:0]  prev_q;
  logic [7:0]  prev_sel;
  logic [7:0]  row;
  logic        cmp_lit;
  logic [7:0]  color_d;

  logic        valid_pixel_q;
  logic [7:0]  color_q;

  assign entry             = (state_q == OUTSIDE) && valid && (x == '0) && (y == '0);
  // The entry cycle addresses the freshly latched half before disp_index_q updates.
  assign read_address      = {entry ? read_index : disp_index_q, x[8:1]};
  assign wave_display_idle = (state_q == OUTSIDE);
  assign in_window         = (x < WAVE_COLS) && (y < WAVE_ROWS);
  // Pixels scanned before a frame entry (e.g. after a mid-frame reset) stay dark.
  assign drawing           = (state_q == DRAWING) || entry;

  // Frame FSM: enter at the origin pixel, leave on the first row past the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OUTSIDE;
      disp_index_q <= 1'b0;
    end else begin
      case (state_q)
        OUTSIDE: if (entry) begin
          state_q      <= DRAWING;
          disp_index_q <= read_index;
        end
        DRAWING: if (valid && y[9]) state_q <= OUTSIDE;
        default: state_q <= OUTSIDE;
      endcase
    end
  end

  // Stage 1: align pixel context with the synchronous RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q <= 1'b0;
      win1_q   <= 1'b0;
      draw1_q  <= 1'b0;
      x1_q     <= '0;
      yh1_q    <= '0;
    end else begin
      valid1_q <= valid;
      win1_q   <= in_window;
      draw1_q  <= drawing;
      x1_q     <= x[8:0];
      yh1_q    <= y[8:1];
    end
  end

  // Remember the sample shown on the second column of each sample pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if (valid1_q && x1_q[0]) begin
      prev_q <= read_value;
    end
  end

  // Select the neighbour sample and convert the row to a level (top = 255).
  always_comb begin
    prev_sel = (x1_q[8:1] == '0) ? read_value : prev_q;
    row      = 8'd255 - yh1_q;
    color_d  = (valid1_q && win1_q && draw1_q && cmp_lit) ? COLOR_LIT : COLOR_UNLIT;
  end

  wave_line_compare u_cmp (
    .prev (prev_sel),
    .cur  (read_value),
    .row  (row),
    .lit  (cmp_lit)
  );

  // Output register: colour and valid two cycles after the pixel coordinates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pixel_q <= 1'b0;
      color_q       <= COLOR_UNLIT;
    end else begin
      valid_pixel_q <= valid1_q;
      color_q       <= color_d;
    end
  end

  assign valid_pixel = valid_pixel_q;
  assign r           = color_q;
  assign g           = color_q;
  assign b           = color_q;

endmodule
